// File: rtl/kw_pkg.sv
// Shared types for the iterative rotator.
package kw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } kw_iter_state_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/kw_ror_iter_if.sv
// Input and output valid/ready channels of the iterative rotator.
interface kw_ror_iter_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_left;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_left, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_left, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/kw_ror_iter_static.sv
// Fixed-amount right rotation; pure wiring.
module KW_ror_static #(
    parameter int WIDTH = 8,
    parameter int ROR   = 1
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] b_o
);

    logic [2*WIDTH-1:0] dbl;

    assign dbl = {a_i, a_i};
    assign b_o = dbl[ROR +: WIDTH];

endmodule

// File: rtl/kw_ror_iter.sv
// Iterative rotator: one power-of-two rotate stage per busy cycle.
module kw_ror_iter
    import kw_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    kw_ror_iter_if.slave  bus
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] STEP_LAST = AMT_W'(AMT_W - 1);

    generate
        if (!is_pow2(WIDTH)) begin : g_bad_width
            $error("kw_ror_iter: WIDTH must be a power of two >= 2");
        end
    endgenerate

    kw_iter_state_t   state_q, state_d;
    logic [AMT_W-1:0] step_q, step_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] eff_q, eff_d;

    logic [WIDTH-1:0] stg [AMT_W];
    logic [WIDTH-1:0] stage_sel;
    logic [AMT_W-1:0] neg_amt;
    logic [AMT_W-1:0] eff_in;
    logic             in_ready;
    logic             out_valid;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        KW_ror_static #(
            .WIDTH (WIDTH),
            .ROR   (2 ** k)
        ) u_ror (
            .a_i (data_q),
            .b_o (stg[k])
        );
    end

    // Left rotation is folded into an equivalent right amount at accept.
    assign neg_amt = AMT_W'(0) - bus.in_amt;
    assign eff_in  = bus.in_left ? neg_amt : bus.in_amt;

    always_comb begin
        stage_sel = data_q;
        for (int k = 0; k < AMT_W; k++) begin
            if (step_q == AMT_W'(k) && eff_q[k]) begin
                stage_sel = stg[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        data_d    = data_q;
        eff_d     = eff_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    eff_d   = eff_in;
                    step_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                data_d = stage_sel;
                step_d = step_q + AMT_W'(1);
                if (step_q == STEP_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        data_d  = bus.in_data;
                        eff_d   = eff_in;
                        step_d  = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            data_q  <= '0;
            eff_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            data_q  <= data_d;
            eff_q   <= eff_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;

endmodule
